// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants, state encoding and helpers for the register dump path
package debug_pkg;

    localparam int DEF_NB_DATA    = 32;
    localparam int DEF_NB_REG     = 5;
    localparam int DEF_SIZE_REG   = 32;
    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = DEF_NB_DATA / NB_BYTE;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NB_BCNT = cnt_width(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/debug_reg_dump_if.sv
// rtl/debug_reg_dump_if.sv - byte stream toward the debug UART transmitter
interface debug_reg_dump_if #(
    parameter int NB_BYTE = debug_pkg::NB_BYTE
);
    logic [NB_BYTE-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - loads a word and shifts it out LSB byte first on valid/ready
module word_byte_serializer #(
    parameter int NB_DATA = debug_pkg::DEF_NB_DATA,
    parameter int NB_BYTE = debug_pkg::NB_BYTE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    debug_reg_dump_if.master   tx,
    output logic               o_last,
    output logic               o_xfer
);
    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = debug_pkg::cnt_width(BPW);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_BYTE-1:0] data_q, data_d;
    logic               valid_q, valid_d;

    assign o_xfer    = valid_q & tx.tready;
    assign o_last    = (cnt_q == NB_CNT'(BPW - 1));
    assign tx.tdata  = data_q;
    assign tx.tvalid = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            shift_d = i_word;
            cnt_d   = '0;
            data_d  = i_word[NB_BYTE-1:0];
            valid_d = 1'b1;
        end else if (o_xfer) begin
            // Last byte only drops valid; data stays put until the next load.
            if (!o_last) begin
                shift_d = shift_q >> NB_BYTE;
                data_d  = shift_d[NB_BYTE-1:0];
                cnt_d   = cnt_q + 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/debug_reg_dump.sv
// rtl/debug_reg_dump.sv - walks the register file debug port and streams every word out as bytes
module debug_reg_dump #(
    parameter int NB_DATA  = debug_pkg::DEF_NB_DATA,
    parameter int NB_REG   = debug_pkg::DEF_NB_REG,
    parameter int SIZE_REG = debug_pkg::DEF_SIZE_REG,
    parameter int NB_BYTE  = debug_pkg::NB_BYTE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic [NB_REG-1:0]  o_reg_address,
    debug_reg_dump_if.master   tx,
    output logic               o_busy,
    output logic               o_done
);
    import debug_pkg::*;

    localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);

    dump_state_e       state_q, state_d;
    logic [NB_REG-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              load;
    logic              last;
    logic              xfer;

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (load),
        .i_word  (i_reg_data),
        .tx      (tx),
        .o_last  (last),
        .o_xfer  (xfer)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Returning through LATCH costs one bubble but lets the read data settle on the new address.
                if (xfer && last) begin
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign o_reg_address = addr_q;
    assign o_done        = done_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_reg_dump.sv
// tb/tb_debug_reg_dump.sv - directed bench for the register dump stream
module tb_debug_reg_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] reg_data;
    logic [4:0]  addr;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];

    debug_reg_dump_if tx ();

    always #5 clk = ~clk;

    assign reg_data = regs[addr];

    debug_reg_dump #(
        .NB_DATA  (32),
        .NB_REG   (5),
        .SIZE_REG (32),
        .NB_BYTE  (8)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_reg_data    (reg_data),
        .o_reg_address (addr),
        .tx            (tx.master),
        .o_busy        (busy),
        .o_done        (done)
    );

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] got [$];
    int         ndone;
    int         done_idx;
    int         first_valid_idx;
    int         busy_low_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: five stall cycles per byte, 2: random ready
    task automatic run_dump(input int mode, input int restart_reg, input bit abort);
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        int         stall;
        bit         restarted;
        bit         finished;
        got.delete();
        ndone = 0; done_idx = -1; first_valid_idx = -1; busy_low_idx = -1;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; stall = 0; restarted = 1'b0; finished = 1'b0;
        start = 1'b1;
        tx.tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 4000 && !finished; idx++) begin
            if (idx > 0) @(negedge clk);
            start = 1'b0;
            if (pv && !pr) begin
                check("hold_valid", 32'(tx.tvalid), 32'd1);
                check("hold_data", 32'(tx.tdata), 32'(pd));
            end
            if (tx.tvalid && first_valid_idx < 0) first_valid_idx = idx;
            if (done) begin
                ndone++;
                done_idx = idx;
            end
            if (idx > 0 && !busy) begin
                busy_low_idx = idx;
                finished = 1'b1;
                tx.tready = 1'b0;
            end else if (abort && got.size() == 30 && tx.tvalid) begin
                rst = 1'b1;
                tx.tready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort_valid", 32'(tx.tvalid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_addr", 32'(addr), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_done_after", 32'(done), 32'd0);
                check("abort_idle", 32'(busy), 32'd0);
                finished = 1'b1;
            end else begin
                if (restart_reg >= 0 && !restarted && 32'(addr) == restart_reg) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end
                case (mode)
                    0: tx.tready = 1'b1;
                    1: begin
                        if (tx.tvalid && stall < 5) begin
                            tx.tready = 1'b0;
                            stall++;
                        end else begin
                            tx.tready = 1'b1;
                            stall = 0;
                        end
                    end
                    default: tx.tready = 1'($urandom_range(0, 1));
                endcase
                if (tx.tvalid && tx.tready) got.push_back(tx.tdata);
            end
            pv = tx.tvalid;
            pr = tx.tready;
            pd = tx.tdata;
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic verify_stream(input string tag);
        logic [31:0] w;
        check({tag, "_nbytes"}, 32'(got.size()), 32'd128);
        for (int i = 0; i < 128 && i < got.size(); i++) begin
            w = regs[i / 4];
            check({tag, "_byte"}, 32'(got[i]), 32'(w[8 * (i % 4) +: 8]));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = i;
        rst = 1'b1;
        start = 1'b1;
        tx.tready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(tx.tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(tx.tdata), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("post_rst_idle2", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(tx.tvalid), 32'd0);

        run_dump(0, -1, 1'b0);
        verify_stream("full");
        check("full_ndone", 32'(ndone), 32'd1);
        check("full_done_idx", 32'(done_idx), 32'd160);
        check("full_first_valid", 32'(first_valid_idx), 32'd1);
        check("full_busy_low", 32'(busy_low_idx), 32'd161);

        regs[3] = 32'hDEADBEEF;
        run_dump(1, -1, 1'b0);
        verify_stream("stall");
        check("stall_ndone", 32'(ndone), 32'd1);
        check("stall_b12", 32'(got.size() > 15 ? got[12] : 8'h00), 32'hEF);
        check("stall_b13", 32'(got.size() > 15 ? got[13] : 8'h00), 32'hBE);
        check("stall_b14", 32'(got.size() > 15 ? got[14] : 8'h00), 32'hAD);
        check("stall_b15", 32'(got.size() > 15 ? got[15] : 8'h00), 32'hDE);

        run_dump(0, 10, 1'b0);
        verify_stream("restart");
        check("restart_ndone", 32'(ndone), 32'd1);
        check("restart_done_idx", 32'(done_idx), 32'd160);

        run_dump(0, -1, 1'b1);
        check("abort_nbytes", 32'(got.size()), 32'd30);
        check("abort_ndone", 32'(ndone), 32'd0);

        run_dump(0, -1, 1'b0);
        verify_stream("after_abort");
        check("after_abort_ndone", 32'(ndone), 32'd1);
        check("after_abort_done_idx", 32'(done_idx), 32'd160);

        run_dump(2, -1, 1'b0);
        verify_stream("random");
        check("random_ndone", 32'(ndone), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
